// File: rtl/branch_pred_pkg.sv
// Shared types and helpers for the branch history table predictor.
// Provides the 2-bit counter encoding, branch-op codes and the counter update function.
package branch_pred_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bht_ctr_t;

  localparam logic [1:0] BRANCH_OP_NONE = 2'b00;
  localparam logic [1:0] BRANCH_OP_JUMP = 2'b01;
  localparam logic [1:0] BRANCH_OP_COND = 2'b11;

  // Saturating step toward the resolved direction; the ends of the range stick.
  function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != STRONG_T) nxt = bht_ctr_t'(ctr + 2'd1);
    end else begin
      if (ctr != STRONG_NT) nxt = bht_ctr_t'(ctr - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_perf_counters.sv
// Retired conditional-branch and mispredict counters for the branch predictor.
// Both counters are free-running 32-bit and wrap to zero.
module branch_perf_counters (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        branch_inc_i,
  input  logic        mispredict_inc_i,
  output logic [31:0] branch_count_o,
  output logic [31:0] mispredict_cnt_o
);

  // Count every cycle in which a conditional branch trains the table.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)        branch_count_o <= 32'h0;
    else if (branch_inc_i) branch_count_o <= branch_count_o + 32'd1;
  end

  // Count every cycle in which the execute-stage branch was mispredicted.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)            mispredict_cnt_o <= 32'h0;
    else if (mispredict_inc_i) mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
  end

endmodule

// File: rtl/branch_history_table.sv
// Dynamic conditional-branch predictor: a tagless table of 2-bit saturating counters,
// looked up combinationally at fetch and trained by resolved branches at execute.
// Optional feature macro: BHT_PERF_CNT_EN adds branch/mispredict performance counters;
// without it the counter ports read zero and no counter flops exist.
module branch_history_table
  import branch_pred_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int INDEX_WIDTH = 6
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [WIDTH-1:0] pc_f_i,
  output logic             pred_taken_f_o,
  input  logic [WIDTH-1:0] pc_e_i,
  input  logic             valid_e_i,
  input  logic             stall_e_i,
  input  logic [1:0]       branch_op_e_i,
  input  logic             pc_src_res_e_i,
  input  logic             pred_taken_e_i,
  output logic             mispredict_e_o,
  output logic [31:0]      branch_count_o,
  output logic [31:0]      mispredict_cnt_o
);

  localparam int TABLE_SIZE = 1 << INDEX_WIDTH;

  bht_ctr_t               table_q [TABLE_SIZE];
  logic [INDEX_WIDTH-1:0] fetch_idx;
  logic [INDEX_WIDTH-1:0] upd_idx;
  logic                   upd;
  logic                   unused_pc_bits;

  // Word-aligned PCs: the byte offset and the bits above the index are dropped, so
  // PCs that share index bits alias onto one counter.
  assign fetch_idx = pc_f_i[INDEX_WIDTH+1:2];
  assign upd_idx   = pc_e_i[INDEX_WIDTH+1:2];
  assign unused_pc_bits = ^{pc_f_i[WIDTH-1:INDEX_WIDTH+2], pc_f_i[1:0],
                            pc_e_i[WIDTH-1:INDEX_WIDTH+2], pc_e_i[1:0]};

  // A stalled branch trains only in the cycle its stall releases; reset masks training
  // so the mispredict flag and counters stay quiet while reset is held.
  assign upd = reset_n_i & valid_e_i & ~stall_e_i & (branch_op_e_i == BRANCH_OP_COND);

  assign mispredict_e_o = upd & (pc_src_res_e_i != pred_taken_e_i);

  // No bypass: a same-index update is seen by fetch one cycle later.
  assign pred_taken_f_o = table_q[fetch_idx][1];

  // Counter table: all entries weakly not-taken on reset, one entry trained per update.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < TABLE_SIZE; i++) table_q[i] <= WEAK_NT;
    end else if (upd) begin
      table_q[upd_idx] <= bht_next(table_q[upd_idx], pc_src_res_e_i);
    end
  end

`ifdef BHT_PERF_CNT_EN
  branch_perf_counters u_perf (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .branch_inc_i     (upd),
    .mispredict_inc_i (mispredict_e_o),
    .branch_count_o   (branch_count_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );
`else
  assign branch_count_o   = 32'h0;
  assign mispredict_cnt_o = 32'h0;
`endif

endmodule
